// File: rtl/liteeth_sram_fifo_ctrl.sv
// Stream FIFO over a 64x64 1RW1R SRAM macro: RW port writes, R port reads.
// A 2-entry output buffer hides the 1-cycle read latency (first-word-fall-through).
module liteeth_sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic [DATA_WIDTH-1:0] sink_data,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [DATA_WIDTH-1:0] source_data,
    output logic [6:0]            level,
    output logic                  mem_rw_ce,
    output logic                  mem_rw_we,
    output logic [ADDR_WIDTH-1:0] mem_rw_addr,
    output logic [DATA_WIDTH-1:0] mem_rw_wd,
    output logic                  mem_r_ce,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_rd
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         ram_count;
    logic                  in_flight;
    logic                  head;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic                  tail;
    logic                  push;
    logic                  pop;
    logic                  fetch;

    always_comb begin
        ram_count    = wr_ptr - rd_ptr;
        sink_ready   = !sys_rst && (ram_count != PW'(DEPTH));
        push         = sink_valid && sink_ready;
        source_valid = !sys_rst && (occ != 2'd0);
        pop          = source_valid && source_ready;
        // occ + in_flight never exceeds 2, so two bits cannot overflow
        occ_next     = occ + {1'b0, in_flight} - {1'b0, pop};
        fetch        = !sys_rst && (ram_count != '0) && (occ_next < 2'd2);
        tail         = head ^ occ[0];
    end

    always_comb begin
        mem_rw_ce   = push;
        mem_rw_we   = push;
        mem_rw_addr = wr_ptr[ADDR_WIDTH-1:0];
        mem_rw_wd   = sink_data;
        mem_r_ce    = fetch;
        mem_r_addr  = rd_ptr[ADDR_WIDTH-1:0];
        source_data = sys_rst ? '0 : obuf[head];
        level       = sys_rst ? 7'd0
                    : 7'(ram_count) + 7'(in_flight) + 7'(occ);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            in_flight <= 1'b0;
            head      <= 1'b0;
            occ       <= 2'd0;
            obuf[0]   <= '0;
            obuf[1]   <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(push);
            rd_ptr    <= rd_ptr + PW'(fetch);
            in_flight <= fetch;
            if (in_flight) obuf[tail] <= mem_r_rd;
            if (pop) head <= ~head;
            occ       <= occ_next;
        end
    end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Bench for liteeth_sram_fifo_ctrl: queue-level reference model plus a
// behavioural 1RW1R macro, randomized and directed stimulus.
module tb_liteeth_sram_fifo_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sink_valid = 1'b0;
    logic        sink_ready;
    logic [63:0] sink_data = '0;
    logic        source_valid;
    logic        source_ready = 1'b0;
    logic [63:0] source_data;
    logic [6:0]  level;
    logic        mem_rw_ce, mem_rw_we, mem_r_ce;
    logic [5:0]  mem_rw_addr, mem_r_addr;
    logic [63:0] mem_rw_wd;
    logic [63:0] mem_r_rd = '0;

    liteeth_sram_fifo_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_data(sink_data),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_data(source_data), .level(level),
        .mem_rw_ce(mem_rw_ce), .mem_rw_we(mem_rw_we),
        .mem_rw_addr(mem_rw_addr), .mem_rw_wd(mem_rw_wd),
        .mem_r_ce(mem_r_ce), .mem_r_addr(mem_r_addr),
        .mem_r_rd(mem_r_rd)
    );

    always #5 sys_clk = ~sys_clk;

    // fakeram macro: RW port writes, R port registered read
    logic [63:0] ram [64];
    always @(posedge sys_clk) begin
        if (mem_rw_ce && mem_rw_we) ram[mem_rw_addr] <= mem_rw_wd;
        if (mem_r_ce) mem_r_rd <= ram[mem_r_addr];
    end

    int tests = 0;
    int fails = 0;

    // reference model: words in RAM, one in flight, words in output buffer
    logic [63:0] ram_q [$];
    logic [63:0] out_q [$];
    bit          fl = 0;
    logic [63:0] fl_d = '0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    // last sampled DUT values and handshakes
    logic        o_sr, o_sv;
    logic [63:0] o_sd;
    logic [6:0]  o_lvl;
    bit          acc, popd;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic sv, input logic [63:0] sd,
                        input logic sr, input logic rst);
        bit e_sr, e_sv, e_push, e_pop, e_fetch;
        int e_lvl;
        @(negedge sys_clk);
        sys_rst = rst;
        sink_valid = sv;
        sink_data = sd;
        source_ready = sr;
        #1;
        if (rst) begin
            e_sr = 0; e_sv = 0; e_push = 0; e_pop = 0; e_fetch = 0;
            e_lvl = 0;
        end else begin
            e_sr = (ram_q.size() != 64);
            e_push = sv && e_sr;
            e_sv = (out_q.size() != 0);
            e_pop = e_sv && sr;
            e_fetch = (ram_q.size() != 0) &&
                      (out_q.size() + int'(fl) - int'(e_pop) < 2);
            e_lvl = ram_q.size() + int'(fl) + out_q.size();
        end
        chk("sink_ready", 64'(sink_ready), 64'(e_sr));
        chk("source_valid", 64'(source_valid), 64'(e_sv));
        chk("level", 64'(level), 64'(e_lvl));
        chk("level_max", 64'(level <= 7'd66), 64'd1);
        chk("mem_rw_ce", 64'(mem_rw_ce), 64'(e_push));
        chk("mem_rw_we", 64'(mem_rw_we), 64'(e_push));
        chk("mem_r_ce", 64'(mem_r_ce), 64'(e_fetch));
        if (rst) chk("source_data_rst", source_data, 64'd0);
        if (e_sv) chk("source_data", source_data, out_q[0]);
        if (e_push) begin
            chk("mem_rw_addr", 64'(mem_rw_addr), 64'(wr_cnt % 64));
            chk("mem_rw_wd", mem_rw_wd, sd);
        end
        if (e_fetch)
            chk("mem_r_addr", 64'(mem_r_addr), 64'(rd_cnt % 64));
        o_sr = sink_ready; o_sv = source_valid;
        o_sd = source_data; o_lvl = level;
        acc = sv && sink_ready;
        popd = source_valid && sr;
        @(posedge sys_clk);
        if (rst) begin
            ram_q.delete(); out_q.delete();
            fl = 0; wr_cnt = 0; rd_cnt = 0;
        end else begin
            if (e_pop) void'(out_q.pop_front());
            if (fl) out_q.push_back(fl_d);
            fl = e_fetch;
            if (e_fetch) begin
                fl_d = ram_q.pop_front();
                rd_cnt++;
            end
            if (e_push) begin
                ram_q.push_back(sd);
                wr_cnt++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (n < 200 && (ram_q.size() + int'(fl) + out_q.size()) != 0) begin
            step(0, 64'd0, 1, 0);
            n++;
        end
        step(0, 64'd0, 1, 0);
        chk("drain_empty", 64'(o_lvl), 64'd0);
    endtask

    initial begin
        int cnt;
        int outs;
        int guard;
        logic [63:0] word;

        // reset state
        step(1, 64'h5, 1, 1);
        step(1, 64'h5, 1, 1);
        chk("rst_sink_ready", 64'(o_sr), 64'd0);
        chk("rst_level", 64'(o_lvl), 64'd0);
        step(0, 64'd0, 0, 0);
        chk("post_rst_sink_ready", 64'(o_sr), 64'd1);
        chk("post_rst_source_valid", 64'(o_sv), 64'd0);

        // single word, 3-edge latency
        step(1, 64'hDEADBEEF_00000001, 1, 0);
        chk("single_lvl0", 64'(o_lvl), 64'd0);
        step(0, 64'd0, 1, 0);
        chk("single_lvl1", 64'(o_lvl), 64'd1);
        chk("single_sv1", 64'(o_sv), 64'd0);
        step(0, 64'd0, 1, 0);
        chk("single_lvl2", 64'(o_lvl), 64'd1);
        chk("single_sv2", 64'(o_sv), 64'd0);
        step(0, 64'd0, 1, 0);
        chk("single_lvl3", 64'(o_lvl), 64'd1);
        chk("single_sv3", 64'(o_sv), 64'd1);
        chk("single_data", o_sd, 64'hDEADBEEF_00000001);
        step(0, 64'd0, 1, 0);
        chk("single_lvl4", 64'(o_lvl), 64'd0);

        // fill with no downstream acceptance
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            step(1, 64'(i), 0, 0);
            if (acc) cnt++;
        end
        chk("fill_accepted", 64'(cnt), 64'd66);
        step(0, 64'd0, 0, 0);
        chk("fill_level", 64'(o_lvl), 64'd66);
        chk("fill_sink_ready", 64'(o_sr), 64'd0);
        // push+pop at 66: push blocked, pop only
        step(1, 64'hAAAA, 1, 0);
        chk("full_pop_data", o_sd, 64'd0);
        chk("full_push_blocked", 64'(acc), 64'd0);
        step(0, 64'd0, 0, 0);
        chk("full_after_pop_lvl", 64'(o_lvl), 64'd65);
        chk("full_after_pop_ready", 64'(o_sr), 64'd1);
        drain();

        // push+pop at level 1
        step(1, 64'h1111, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 64'd0, 0, 0);
        step(1, 64'h2222, 1, 0);
        chk("lvl1_before", 64'(o_lvl), 64'd1);
        chk("lvl1_pop_data", o_sd, 64'h1111);
        step(0, 64'd0, 0, 0);
        chk("lvl1_after", 64'(o_lvl), 64'd1);
        drain();

        // streaming 200 words
        cnt = 0; outs = 0; guard = 0;
        while (cnt < 200 && guard < 400) begin
            step(1, 64'h5000 + 64'(cnt), 1, 0);
            if (acc) cnt++;
            if (popd) outs++;
            guard++;
        end
        chk("stream_cycles", 64'(guard), 64'd200);
        for (int i = 0; i < 10; i++) begin
            step(0, 64'd0, 1, 0);
            if (popd) outs++;
        end
        chk("stream_out", 64'(outs), 64'd200);

        // reset mid-stream drops everything
        for (int i = 0; i < 5; i++) step(1, 64'h7700 + 64'(i), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 64'h7800, 1, 1);
            chk("mid_rst_ready", 64'(o_sr), 64'd0);
            chk("mid_rst_valid", 64'(o_sv), 64'd0);
            chk("mid_rst_level", 64'(o_lvl), 64'd0);
        end
        step(0, 64'd0, 1, 0);
        chk("mid_rel_ready", 64'(o_sr), 64'd1);
        chk("mid_rel_valid", 64'(o_sv), 64'd0);

        // random backpressure, 1000 words
        cnt = 0; guard = 0;
        while (cnt < 1000 && guard < 8000) begin
            word = {$urandom, $urandom};
            step(1'($urandom_range(0, 1)), word,
                 1'($urandom_range(0, 1)), 0);
            if (acc) cnt++;
            guard++;
        end
        chk("rand_accepted", 64'(cnt), 64'd1000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
